// File: rtl/mul_share_arb_if.sv
// Request, multiplier-tree and response signals shared between the mul_share_arb
// arbiter (slave side) and its requesters / multiplier tree (master side).
interface mul_share_arb_if #(
    parameter int W = 58
);
    logic           m_req_valid;
    logic           m_req_ready;
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;

    logic           d_req_valid;
    logic           d_req_ready;
    logic [W-1:0]   d_a;
    logic [W-1:0]   d_b;
    logic           d_lock;

    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_p;

    logic           m_rsp_valid;
    logic           d_rsp_valid;
    logic [2*W-1:0] rsp_p;
    logic           busy;

    modport master (
        output m_req_valid, m_a, m_b,
        output d_req_valid, d_a, d_b, d_lock,
        output mul_p,
        input  m_req_ready, d_req_ready,
        input  mul_a, mul_b,
        input  m_rsp_valid, d_rsp_valid, rsp_p, busy
    );

    modport slave (
        input  m_req_valid, m_a, m_b,
        input  d_req_valid, d_a, d_b, d_lock,
        input  mul_p,
        output m_req_ready, d_req_ready,
        output mul_a, mul_b,
        output m_rsp_valid, d_rsp_valid, rsp_p, busy
    );
endinterface

// File: rtl/mul_share_arb.sv
// Shares one W x W multiplier tree between the FP multiply path (M) and the divide
// sequencer (D). Optional lock-length limit: `define MUL_ARB_LOCK_LIMIT_EN.
module mul_share_arb #(
    parameter int W        = 58,
    parameter int LAT      = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_share_arb_if.slave bus
);

    if (LAT < 1 || LOCK_MAX < 1) begin : g_bad_param
        $error("mul_share_arb: LAT and LOCK_MAX must both be >= 1");
    end

    typedef enum logic [0:0] {
        ST_RR     = 1'b0,
        ST_LOCK_D = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           prio_d;
    logic           prio_d_nxt;
    logic           grant_m;
    logic           grant_d;
    logic           accept;
    logic           lock_force;

    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   opa_p0;
    logic [W-1:0]   opb_p0;
    logic [LAT:0]   vld_p;
    logic [LAT:0]   tag_p;
    logic [2*W-1:0] prod_out;

`ifdef MUL_ARB_LOCK_LIMIT_EN
    localparam int               CNT_W     = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    logic [CNT_W-1:0] lock_cnt;

    // Counts LOCK_D cycles already spent; saturates so a starved lock stays forcible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if (state != ST_LOCK_D) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_LAST) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
        end
    end

    assign lock_force = (lock_cnt == LOCK_LAST) && bus.m_req_valid;
`else
    assign lock_force = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RR;
            prio_d <= 1'b1;
        end else begin
            state  <= state_nxt;
            prio_d <= prio_d_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        prio_d_nxt = prio_d;
        grant_m    = 1'b0;
        grant_d    = 1'b0;
        unique case (state)
            ST_RR: begin
                if (bus.d_req_valid && (prio_d || !bus.m_req_valid)) begin
                    grant_d = 1'b1;
                end else if (bus.m_req_valid) begin
                    grant_m = 1'b1;
                end
                if (grant_d) begin
                    prio_d_nxt = 1'b0;
                    if (bus.d_lock) begin
                        state_nxt = ST_LOCK_D;
                    end
                end else if (grant_m) begin
                    prio_d_nxt = 1'b1;
                end
            end
            ST_LOCK_D: begin
                // D may still issue in the cycle it releases the lock.
                grant_d = bus.d_req_valid;
                if (!bus.d_lock || lock_force) begin
                    state_nxt  = ST_RR;
                    prio_d_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_RR;
            end
        endcase
    end

    assign accept          = grant_m | grant_d;
    assign bus.m_req_ready = grant_m;
    assign bus.d_req_ready = grant_d;

    assign op_a = grant_d ? bus.d_a : bus.m_a;
    assign op_b = grant_d ? bus.d_b : bus.m_b;

    // Stage p0: operands presented to the multiplier tree; they hold between accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_p0 <= '0;
            opb_p0 <= '0;
        end else if (accept) begin
            opa_p0 <= op_a;
            opb_p0 <= op_b;
        end
    end

    // Tag pipe: bit k is the op accepted k+1 cycles ago; tag 1 means it belongs to D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            tag_p <= '0;
        end else begin
            vld_p <= {vld_p[LAT-1:0], accept};
            tag_p <= {tag_p[LAT-1:0], grant_d};
        end
    end

    // Stage LAT: product is valid on mul_p, capture it for the response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_out <= '0;
        end else if (vld_p[LAT-1]) begin
            prod_out <= bus.mul_p;
        end
    end

    assign bus.mul_a       = opa_p0;
    assign bus.mul_b       = opb_p0;
    assign bus.rsp_p       = prod_out;
    assign bus.m_rsp_valid = vld_p[LAT] & ~tag_p[LAT];
    assign bus.d_rsp_valid = vld_p[LAT] & tag_p[LAT];
    assign bus.busy        = (|vld_p) | (state == ST_LOCK_D);

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Arbitrates one shared 58x58 multiplier tree between two requesters: the FP multiply path (M) and the Newton–Raphson divide sequencer (D).
- Registers the winning operands onto the multiplier inputs and tracks in-flight tags through the multiplier latency.
- Returns each product to the requester that issued it.
- Supports a divider lock, so an iteration chain (x·b, A·x, a·x) runs without interleaved M operations.

Parameters:
- W, 58, operand width; product width is 2W.
- LAT, 1, cycles from operand registers to valid mul_p (1 = combinational tree); must be ≥1.
- LOCK_MAX, 16, maximum consecutive lock cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_req_valid  in  1  M request valid
- m_req_ready  out  1  M request accepted this cycle
- m_a, m_b  in  W  M operands
- d_req_valid  in  1  D request valid
- d_req_ready  out  1  D request accepted this cycle
- d_a, d_b  in  W  D operands
- d_lock  in  1  D asks to keep ownership after this grant
- mul_a, mul_b  out  W  registered operands to multiplier tree
- mul_p  in  2W  multiplier product
- m_rsp_valid  out  1  rsp_p belongs to M (1-cycle pulse)
- d_rsp_valid  out  1  rsp_p belongs to D (1-cycle pulse)
- rsp_p  out  2W  registered product
- busy  out  1  any op in flight or FSM in LOCK_D

Behaviour:
- Reset: state RR, prio=D (D wins first conflict), tag pipe cleared, mul_a/mul_b/rsp_p=0, m_rsp_valid=d_rsp_valid=0, busy=0.
- Ready signals are combinational from valids and state; ready may depend on valid. Valid must not depend on ready.
- Handshake: accept = valid & ready. At most one accept per cycle. Fully pipelined, so back-to-back accepts are allowed every cycle.
- RR state:
  - Only one valid: grant it.
  - Both valid: grant the side named by prio.
  - After any grant, prio flips to the other side.
  - A D grant with d_lock=1 moves to LOCK_D.
- LOCK_D state:
  - m_req_ready=0; d_req_ready=d_req_valid.
  - Leave for RR on the first cycle d_lock=0, whether or not D also issues that cycle.
  - prio becomes M on exit.
- Datapath:
  - On accept, the operands are registered into mul_a/mul_b at that edge.
  - The tag (M/D) and valid enter a shift pipe of depth LAT+1.
  - At the edge ending cycle LAT after accept, mul_p is captured into rsp_p.
  - The matching rsp_valid is high in cycle LAT+1. Total latency = LAT+1 cycles from accept.
- mul_a/mul_b hold their last value when no accept occurs (no gating to zero).
- rsp_p holds its last value when no response is due.
- Simultaneous accept and response in the same cycle are independent; there is no stall path.
- Responders have no backpressure: the consumer must sample in the pulse cycle.
- Reset mid-operation: all in-flight ops are dropped, no rsp pulse is emitted, and the FSM returns to RR.
- Width rule: rsp_p = mul_p unmodified (full 2W). Truncation/selection is the requester's job.

Optional Feature:
- Macro MUL_ARB_LOCK_LIMIT_EN.
- When defined:
  - A lock counter counts cycles spent in LOCK_D.
  - On reaching LOCK_MAX with m_req_valid=1, force exit to RR with prio=M, ignoring d_lock.
  - D must re-request the lock on its next grant.
  - The counter clears on entering LOCK_D.
- When undefined: the lock is held indefinitely while d_lock=1. No counter logic is present.

Test Plan:
- Single M: m_a=3, m_b=5, LAT=1 → m_rsp_valid pulses 2 cycles after accept with rsp_p=15; d_rsp_valid stays 0.
- Conflict after reset: both valid in the same cycle → D accepted first, M accepted next cycle; responses arrive D then M in consecutive cycles.
- Streaming alternation: M and D held valid for 8 cycles → grants strictly alternate, 8 accepts, 8 responses with correct tags, no bubbles.
- Lock: D issues with d_lock=1 for 3 ops while M is valid → m_req_ready=0 for those cycles; M is granted the cycle after d_lock drops.
- Reset while 2 ops are in flight → no rsp pulses afterwards, busy=0; the next accepted op returns correctly.
- With MUL_ARB_LOCK_LIMIT_EN and LOCK_MAX=4: D holds d_lock=1 while M is valid → M is granted after 4 lock cycles.
